div_issue_ctrl: RTL and testbench

Execute-stage sequencer that sits between the ID/EX pipeline register and the iterative divider. It decodes the eight RV64M divide/remainder opcodes and prepares operands, including W-variant truncation and extension. It resolves divide-by-zero and signed overflow itself, without launching the divider. Otherwise it launches the divider, holds its request until finish, captures the result, sign-extends W results and presents a single-cycle write-back to the pipeline while stalling upstream.

---
 rtl/div_issue_ctrl_pkg.sv | 19 +
 rtl/div_operand_prep.sv | 72 +++++++
 rtl/div_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_div_issue_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divide issue controller.
// Opcode encodings and datapath constants.
package div_issue_ctrl_pkg;

  localparam int XLEN  = 64;
  localparam int OPC_W = 8;

  localparam logic [OPC_W-1:0] INST_DIV   = 8'h40;
  localparam logic [OPC_W-1:0] INST_DIVU  = 8'h41;
  localparam logic [OPC_W-1:0] INST_REM   = 8'h42;
  localparam logic [OPC_W-1:0] INST_REMU  = 8'h43;
  localparam logic [OPC_W-1:0] INST_DIVW  = 8'h44;
  localparam logic [OPC_W-1:0] INST_DIVUW = 8'h45;
  localparam logic [OPC_W-1:0] INST_REMW  = 8'h46;
  localparam logic [OPC_W-1:0] INST_REMUW = 8'h47;

  localparam logic [XLEN-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/div_operand_prep.sv
// Decodes divide opcodes, prepares W-variant operands and
// resolves divide-by-zero and signed overflow results.
module div_operand_prep
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN_P  = XLEN,
  parameter int OPC_W_P = OPC_W
) (
  input  logic [OPC_W_P-1:0] opcode,
  input  logic [XLEN_P-1:0]  rs1,
  input  logic [XLEN_P-1:0]  rs2,
  output logic [XLEN_P-1:0]  numer,
  output logic [XLEN_P-1:0]  denom,
  output logic               is_div,
  output logic               is_w,
  output logic               is_special,
  output logic [XLEN_P-1:0]  special_result
);

  logic is_sgn;
  logic is_rem;
  logic den_zero;
  logic ovf;
  logic [XLEN_P-1:0] min_neg;

  always_comb begin
    is_div = 1'b0;
    is_w   = 1'b0;
    is_sgn = 1'b0;
    is_rem = 1'b0;
    unique case (opcode)
      OPC_W_P'(INST_DIV):   begin is_div = 1'b1; is_sgn = 1'b1; end
      OPC_W_P'(INST_DIVU):  begin is_div = 1'b1; end
      OPC_W_P'(INST_REM):   begin is_div = 1'b1; is_sgn = 1'b1; is_rem = 1'b1; end
      OPC_W_P'(INST_REMU):  begin is_div = 1'b1; is_rem = 1'b1; end
      OPC_W_P'(INST_DIVW):  begin is_div = 1'b1; is_w = 1'b1; is_sgn = 1'b1; end
      OPC_W_P'(INST_DIVUW): begin is_div = 1'b1; is_w = 1'b1; end
      OPC_W_P'(INST_REMW):  begin is_div = 1'b1; is_w = 1'b1; is_sgn = 1'b1; is_rem = 1'b1; end
      OPC_W_P'(INST_REMUW): begin is_div = 1'b1; is_w = 1'b1; is_rem = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    numer = rs1;
    denom = rs2;
    if (is_w && is_sgn) begin
      numer = {{(XLEN_P-32){rs1[31]}}, rs1[31:0]};
      denom = {{(XLEN_P-32){rs2[31]}}, rs2[31:0]};
    end else if (is_w) begin
      numer = {{(XLEN_P-32){1'b0}}, rs1[31:0]};
      denom = {{(XLEN_P-32){1'b0}}, rs2[31:0]};
    end
  end

  // W overflow numerator is the sign-extended 32-bit minimum
  assign min_neg = is_w ? {{(XLEN_P-32){1'b1}}, 1'b1, 31'b0}
                        : {1'b1, {(XLEN_P-1){1'b0}}};

  assign den_zero   = (denom == '0);
  assign ovf        = is_sgn && (denom == '1) && (numer == min_neg);
  assign is_special = is_div && (den_zero || ovf);

  always_comb begin
    special_result = '0;
    if (den_zero)
      special_result = is_rem ? numer : '1;
    else if (ovf)
      special_result = is_rem ? '0 : numer;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Execute-stage sequencer for the iterative divider: accept,
// launch, wait for finish or timeout, then one-cycle write-back.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN        = div_issue_ctrl_pkg::XLEN,
  parameter int OPC_W       = div_issue_ctrl_pkg::OPC_W,
  parameter int TIMEOUT_CYC = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [OPC_W-1:0] ex_opcode,
  input  logic [XLEN-1:0]  ex_rs1_data,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic [4:0]       ex_rd_addr,
  input  logic             flush,
  output logic             stall_req,
  output logic             wb_valid,
  output logic [XLEN-1:0]  wb_data,
  output logic [4:0]       wb_rd,
  output logic             div_err,
  output logic [XLEN-1:0]  dv_numer,
  output logic [XLEN-1:0]  dv_denom,
  output logic [OPC_W-1:0] dv_opcode,
  output logic             dv_ready,
  input  logic [XLEN-1:0]  dv_result,
  input  logic             dv_finish
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state;

  logic [CW-1:0]    cnt;
  logic [OPC_W-1:0] opc_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  numer_q;
  logic [XLEN-1:0]  denom_q;
  logic             is_w_q;

  logic [XLEN-1:0] p_numer;
  logic [XLEN-1:0] p_denom;
  logic            p_is_div;
  logic            p_is_w;
  logic            p_special;
  logic [XLEN-1:0] p_result;
  logic            accept;

  div_operand_prep #(
    .XLEN_P  (XLEN),
    .OPC_W_P (OPC_W)
  ) u_prep (
    .opcode         (ex_opcode),
    .rs1            (ex_rs1_data),
    .rs2            (ex_rs2_data),
    .numer          (p_numer),
    .denom          (p_denom),
    .is_div         (p_is_div),
    .is_w           (p_is_w),
    .is_special     (p_special),
    .special_result (p_result)
  );

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  assign accept    = (state == S_IDLE) && ex_valid && p_is_div && !flush;
  assign stall_req = accept || (state == S_BUSY);

  // Divider-facing operands are only visible while a request is up
  assign dv_numer  = dv_ready ? numer_q : '0;
  assign dv_denom  = dv_ready ? denom_q : '0;
  assign dv_opcode = dv_ready ? opc_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      opc_q    <= '0;
      rd_q     <= '0;
      numer_q  <= '0;
      denom_q  <= '0;
      is_w_q   <= 1'b0;
      dv_ready <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      div_err  <= 1'b0;
    end else if (flush) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dv_ready <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      div_err  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      div_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            opc_q   <= ex_opcode;
            rd_q    <= ex_rd_addr;
            numer_q <= p_numer;
            denom_q <= p_denom;
            is_w_q  <= p_is_w;
            cnt     <= '0;
            if (p_special) begin
              state    <= S_DONE;
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd_addr;
              wb_data  <= p_is_w ? sext32(p_result) : p_result;
            end else begin
              state    <= S_BUSY;
              dv_ready <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (dv_finish) begin
            state    <= S_DONE;
            dv_ready <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= is_w_q ? sext32(dv_result) : dv_result;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            state    <= S_DONE;
            dv_ready <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= ZERO_WORD;
            div_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a cycle-driven divider model.
// Inputs change and outputs are sampled on the falling edge.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [7:0]  ex_opcode;
  logic [63:0] ex_rs1_data;
  logic [63:0] ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        flush;
  logic        stall_req;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        div_err;
  logic [63:0] dv_numer;
  logic [63:0] dv_denom;
  logic [7:0]  dv_opcode;
  logic        dv_ready;
  logic [63:0] dv_result;
  logic        dv_finish;

  int n_chk = 0;
  int n_err = 0;

  div_issue_ctrl #(
    .XLEN        (64),
    .OPC_W       (8),
    .TIMEOUT_CYC (80)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_rd_addr  (ex_rd_addr),
    .flush       (flush),
    .stall_req   (stall_req),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .div_err     (div_err),
    .dv_numer    (dv_numer),
    .dv_denom    (dv_denom),
    .dv_opcode   (dv_opcode),
    .dv_ready    (dv_ready),
    .dv_result   (dv_result),
    .dv_finish   (dv_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    ex_valid    = 1'b1;
    ex_opcode   = op;
    ex_rs1_data = a;
    ex_rs2_data = b;
    ex_rd_addr  = rd;
  endtask

  task automatic idle_in();
    ex_valid    = 1'b0;
    ex_opcode   = 8'h00;
    ex_rs1_data = '0;
    ex_rs2_data = '0;
    ex_rd_addr  = '0;
  endtask

  // Special-case op: write-back one cycle after accept, divider untouched
  task automatic run_spec(input string tag, input logic [7:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic [63:0] exp);
    @(negedge clk);
    drive(op, a, b, rd);
    #1 chk({tag, "_stall"}, 64'(stall_req), 64'd1);
    @(negedge clk);
    idle_in();
    chk({tag, "_wbv"}, 64'(wb_valid), 64'd1);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_rd"}, 64'(wb_rd), 64'(rd));
    chk({tag, "_nordy"}, 64'(dv_ready), 64'd0);
    @(negedge clk);
    chk({tag, "_wbv_off"}, 64'(wb_valid), 64'd0);
  endtask

  // Normal op: divider model raises finish on BUSY cycle lat
  task automatic run_norm(input string tag, input logic [7:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic [63:0] en,
                          input logic [63:0] ed, input int lat,
                          input logic [63:0] res, input logic [63:0] exp);
    int bad;
    bad = 0;
    @(negedge clk);
    drive(op, a, b, rd);
    #1 chk({tag, "_stall"}, 64'(stall_req), 64'd1);
    @(negedge clk);
    idle_in();
    for (int i = 1; i <= lat; i++) begin
      if (i == 1) begin
        chk({tag, "_numer"}, dv_numer, en);
        chk({tag, "_denom"}, dv_denom, ed);
        chk({tag, "_opc"}, 64'(dv_opcode), 64'(op));
      end
      if (!dv_ready || !stall_req || wb_valid ||
          dv_numer !== en || dv_denom !== ed)
        bad++;
      if (i == lat) begin
        dv_finish = 1'b1;
        dv_result = res;
      end
      @(negedge clk);
      dv_finish = 1'b0;
      dv_result = '0;
    end
    chk({tag, "_busy"}, 64'(bad), 64'd0);
    chk({tag, "_wbv"}, 64'(wb_valid), 64'd1);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_rd"}, 64'(wb_rd), 64'(rd));
    chk({tag, "_rdy_off"}, 64'(dv_ready), 64'd0);
    chk({tag, "_stall_off"}, 64'(stall_req), 64'd0);
    @(negedge clk);
    chk({tag, "_wbv_off"}, 64'(wb_valid), 64'd0);
  endtask

  initial begin
    int n;
    int busy;
    int seen;
    rst       = 1'b1;
    flush     = 1'b0;
    dv_finish = 1'b0;
    dv_result = '0;
    idle_in();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_outs", {stall_req, wb_valid, div_err, dv_ready, wb_rd},
        64'd0);
    chk("rst_data", wb_data | dv_numer | dv_denom | 64'(dv_opcode), 64'd0);

    // Non-divide opcode is ignored
    drive(8'h13, 64'd9, 64'd3, 5'd4);
    #1 chk("nondiv_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    idle_in();
    chk("nondiv_outs", {wb_valid, dv_ready, stall_req}, 64'd0);

    run_norm("div_neg", INST_DIV, 64'd100, -64'sd7, 5'd3,
             64'd100, -64'sd7, 66, 64'hFFFF_FFFF_FFFF_FFF2,
             64'hFFFF_FFFF_FFFF_FFF2);
    run_norm("remu", INST_REMU, 64'd100, 64'd7, 5'd9,
             64'd100, 64'd7, 5, 64'd2, 64'd2);
    run_norm("divuw", INST_DIVUW, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 5'd17,
             64'h0000_0000_FFFF_FFFE, 64'd1, 66,
             64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE);

    run_spec("divu_z", INST_DIVU, 64'd5, 64'd0, 5'd1, '1);
    run_spec("remu_z", INST_REMU, 64'd5, 64'd0, 5'd2, 64'd5);
    run_spec("div_ovf", INST_DIV, 64'h8000_0000_0000_0000, '1, 5'd5,
             64'h8000_0000_0000_0000);
    run_spec("remw_ovf", INST_REMW, 64'h0000_0000_8000_0000, '1, 5'd6,
             64'd0);
    run_spec("divw_ovf", INST_DIVW, 64'h0000_0000_8000_0000,
             64'h0000_0000_FFFF_FFFF, 5'd7, 64'hFFFF_FFFF_8000_0000);
    run_spec("remuw_z", INST_REMUW, 64'h1234_5678_8000_0001,
             64'hABCD_0000_0000_0000, 5'd8, 64'hFFFF_FFFF_8000_0001);

    // Flush 10 cycles into BUSY, then a stray finish in IDLE
    @(negedge clk);
    drive(INST_DIV, 64'd9, 64'd2, 5'd10);
    @(negedge clk);
    idle_in();
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      if (dv_ready) busy++;
      if (i == 9) flush = 1'b1;
      @(negedge clk);
    end
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd10);
    chk("flush_rdy", 64'(dv_ready), 64'd0);
    chk("flush_stall", 64'(stall_req), 64'd0);
    seen = 0;
    dv_finish = 1'b1;
    dv_result = 64'd4;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        dv_finish = 1'b0;
        dv_result = '0;
      end
      if (wb_valid || div_err || dv_ready) seen++;
      @(negedge clk);
    end
    chk("flush_stray_fin", 64'(seen), 64'd0);

    // Flush wins over a same-cycle accept
    drive(INST_DIV, 64'd9, 64'd2, 5'd11);
    flush = 1'b1;
    #1 chk("flush_acc_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    idle_in();
    chk("flush_acc_rdy", {wb_valid, dv_ready}, 64'd0);

    // Divider never finishes: forced abort
    @(negedge clk);
    drive(INST_DIV, 64'd7, 64'd2, 5'd12);
    @(negedge clk);
    idle_in();
    n = 0;
    busy = 0;
    while (!wb_valid && n < 200) begin
      if (dv_ready) busy++;
      @(negedge clk);
      n++;
    end
    chk("to_wbv", 64'(wb_valid), 64'd1);
    chk("to_cycles", 64'(busy), 64'd80);
    chk("to_err", 64'(div_err), 64'd1);
    chk("to_data", wb_data, 64'd0);
    chk("to_rd", 64'(wb_rd), 64'd12);
    @(negedge clk);
    chk("to_after", {wb_valid, div_err, dv_ready, stall_req}, 64'd0);

    // Reset in the middle of an operation
    drive(INST_DIVU, 64'd50, 64'd5, 5'd13);
    @(negedge clk);
    idle_in();
    repeat (5) @(negedge clk);
    chk("rst_mid_busy", 64'(dv_ready), 64'd1);
    rst = 1'b1;
    dv_finish = 1'b1;
    dv_result = 64'd10;
    @(negedge clk);
    rst = 1'b0;
    dv_finish = 1'b0;
    dv_result = '0;
    chk("rst_mid_outs", {dv_ready, stall_req, wb_valid, div_err}, 64'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (wb_valid || dv_ready) seen++;
      @(negedge clk);
    end
    chk("rst_mid_quiet", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
